// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by decode and execute: opcodes, operand selects, ALU ops,
// branch/writeback selects, immediate formats and the ID/EX payload.
package riscv_pkg;

    localparam logic [6:0] OpcOp    = 7'h33;
    localparam logic [6:0] OpcOpImm = 7'h13;
    localparam logic [6:0] OpcLoad  = 7'h03;
    localparam logic [6:0] OpcStore = 7'h23;
    localparam logic [6:0] OpcLui   = 7'h37;
    localparam logic [6:0] OpcAuipc = 7'h17;
    localparam logic [6:0] OpcJal   = 7'h6f;
    localparam logic [6:0] OpcJalr  = 7'h67;
    localparam logic [6:0] OpcBranch = 7'h63;

    typedef enum logic [1:0] {ASelRs1 = 2'd0, ASelPc = 2'd1, ASelZero = 2'd2} asel_e;
    typedef enum logic [1:0] {BSelRs2 = 2'd0, BSelImm = 2'd1, BSelFour = 2'd2} bsel_e;

    typedef enum logic [3:0] {
        AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3, AluSltu = 4'd4,
        AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7, AluOr = 4'd8, AluAnd = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BrNone = 3'd0, BrEq = 3'd1, BrNe = 3'd2, BrLt = 3'd3, BrGe = 3'd4,
        BrJal = 3'd5, BrJalr = 3'd6
    } br_type_e;

    typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wb_sel_e;

    typedef enum logic [2:0] {
        ImmNone = 3'd0, ImmI = 3'd1, ImmS = 3'd2, ImmB = 3'd3, ImmU = 3'd4, ImmJ = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] data_a;
        logic [31:0] data_b;
        asel_e       asel;
        bsel_e       bsel;
        alu_op_e     alu_op;
        logic        br_un;
        br_type_e    br_type;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
        logic        wb_en;
        wb_sel_e     wb_sel;
        logic [4:0]  rd;
        logic        illegal;
    } id_ex_t;

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            ImmI:    gen_imm = {{20{i[31]}}, i[31:20]};
            ImmS:    gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            ImmB:    gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            ImmU:    gen_imm = {i[31:12], 12'b0};
            ImmJ:    gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

    // alt selects SUB/SRA; callers only raise it where that encoding is legal.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        unique case (f3)
            3'd0: alu_from_f3 = alt ? AluSub : AluAdd;
            3'd1: alu_from_f3 = AluSll;
            3'd2: alu_from_f3 = AluSlt;
            3'd3: alu_from_f3 = AluSltu;
            3'd4: alu_from_f3 = AluXor;
            3'd5: alu_from_f3 = alt ? AluSra : AluSrl;
            3'd6: alu_from_f3 = AluOr;
            3'd7: alu_from_f3 = AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-to-execute operand/control bundle; decode is the master, execute the slave.
interface id_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_DataA;
    logic [31:0] ex_DataB;
    logic [1:0]  ex_ASel;
    logic [1:0]  ex_BSel;
    logic [3:0]  ex_ALUop;
    logic        ex_BrUn;
    logic [2:0]  ex_br_type;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [2:0]  ex_funct3;
    logic        ex_wb_en;
    logic [1:0]  ex_wb_sel;
    logic [4:0]  ex_rd;
    logic        ex_illegal;

    modport master (
        output ex_valid, ex_pc, ex_imm, ex_DataA, ex_DataB, ex_ASel, ex_BSel, ex_ALUop,
               ex_BrUn, ex_br_type, ex_mem_re, ex_mem_we, ex_funct3, ex_wb_en, ex_wb_sel,
               ex_rd, ex_illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_pc, ex_imm, ex_DataA, ex_DataB, ex_ASel, ex_BSel, ex_ALUop,
               ex_BrUn, ex_br_type, ex_mem_re, ex_mem_we, ex_funct3, ex_wb_en, ex_wb_sel,
               ex_rd, ex_illegal,
        output ex_ready
    );
endinterface

// File: rtl/regfile.sv
// Integer register file: two combinational read ports with write-through, one write port,
// x0 hardwired to zero. Contents are deliberately not reset.
module regfile #(
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    output logic [31:0]   rdata_a_o,
    output logic [31:0]   rdata_b_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);
    logic [31:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (we_i && waddr_i != '0) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = mem[ra_i];
        rdata_b_o = mem[rb_i];
        if (we_i && waddr_i == ra_i) rdata_a_o = wdata_i;
        if (we_i && waddr_i == rb_i) rdata_b_o = wdata_i;
        if (ra_i == '0) rdata_a_o = '0;
        if (rb_i == '0) rdata_b_o = '0;
    end
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads operands, detects load-use
// hazards and registers the result into the ID/EX pipeline register.
module id_stage
    import riscv_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    id_stage_if.master  ex
);
    localparam int unsigned AW = $clog2(NREG);

    logic [6:0]  opcode, funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] rdata_a, rdata_b;
    logic        use_rs1, use_rs2, hazard, adv, load;
    imm_fmt_e    fmt;
    id_ex_t      dec, ex_q;
    logic        valid_q;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    regfile #(.NREG(NREG)) u_regfile (
        .clk       (clk),
        .ra_i      (rs1[AW-1:0]),
        .rb_i      (rs2[AW-1:0]),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (wb_en),
        .waddr_i   (wb_rd[AW-1:0]),
        .wdata_i   (wb_data)
    );

    always_comb begin
        dec        = '0;
        fmt        = ImmNone;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.pc     = if_pc;
        dec.data_a = rdata_a;
        dec.data_b = rdata_b;
        dec.funct3 = funct3;
        dec.rd     = rd;
        case (opcode)
            OpcOp: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.wb_en = 1'b1;
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))
                    dec.alu_op = alu_from_f3(funct3, funct7[5]);
                else
                    dec.illegal = 1'b1;
            end
            OpcOpImm: begin
                use_rs1 = 1'b1;
                fmt = ImmI;
                dec.bsel = BSelImm;
                dec.wb_en = 1'b1;
                if ((funct3 == 3'd1 && funct7 != 7'h00) ||
                    (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20))
                    dec.illegal = 1'b1;
                else
                    dec.alu_op = alu_from_f3(funct3, funct3 == 3'd5 && funct7[5]);
            end
            OpcLoad: begin
                use_rs1 = 1'b1;
                fmt = ImmI;
                dec.bsel = BSelImm;
                dec.mem_re = 1'b1;
                dec.wb_en = 1'b1;
                dec.wb_sel = WbMem;
                dec.illegal = (funct3 == 3'd3 || funct3 > 3'd5);
            end
            OpcStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fmt = ImmS;
                dec.bsel = BSelImm;
                dec.mem_we = 1'b1;
                dec.illegal = (funct3 > 3'd2);
            end
            OpcLui: begin
                fmt = ImmU;
                dec.asel = ASelZero;
                dec.bsel = BSelImm;
                dec.wb_en = 1'b1;
            end
            OpcAuipc: begin
                fmt = ImmU;
                dec.asel = ASelPc;
                dec.bsel = BSelImm;
                dec.wb_en = 1'b1;
            end
            OpcJal: begin
                fmt = ImmJ;
                dec.asel = ASelPc;
                dec.bsel = BSelImm;
                dec.br_type = BrJal;
                dec.wb_en = 1'b1;
                dec.wb_sel = WbPc4;
            end
            OpcJalr: begin
                use_rs1 = 1'b1;
                fmt = ImmI;
                dec.bsel = BSelImm;
                dec.br_type = BrJalr;
                dec.wb_en = 1'b1;
                dec.wb_sel = WbPc4;
                dec.illegal = (funct3 != 3'd0);
            end
            OpcBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fmt = ImmB;
                dec.asel = ASelPc;
                dec.bsel = BSelImm;
                dec.br_un = funct3[1];
                case (funct3)
                    3'd0:       dec.br_type = BrEq;
                    3'd1:       dec.br_type = BrNe;
                    3'd4, 3'd6: dec.br_type = BrLt;
                    3'd5, 3'd7: dec.br_type = BrGe;
                    default:    dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings collapse to a side-effect-free NOP.
        if (dec.illegal) begin
            fmt         = ImmNone;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
            dec.asel    = ASelRs1;
            dec.bsel    = BSelRs2;
            dec.alu_op  = AluAdd;
            dec.br_un   = 1'b0;
            dec.br_type = BrNone;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.wb_en   = 1'b0;
            dec.wb_sel  = WbAlu;
        end
        if (!dec.wb_en) dec.rd = '0;
        dec.imm = gen_imm(fmt, if_instr);
    end

    assign hazard = valid_q && ex_q.mem_re && ex_q.rd != '0 &&
                    ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
    assign adv      = !valid_q || ex.ex_ready;
    assign if_ready = adv && !hazard;
    assign load     = if_valid && !hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (adv) begin
            valid_q <= load;
            if (load) ex_q <= dec;
        end
    end

    assign ex.ex_valid   = valid_q;
    assign ex.ex_pc      = ex_q.pc;
    assign ex.ex_imm     = ex_q.imm;
    assign ex.ex_DataA   = ex_q.data_a;
    assign ex.ex_DataB   = ex_q.data_b;
    assign ex.ex_ASel    = ex_q.asel;
    assign ex.ex_BSel    = ex_q.bsel;
    assign ex.ex_ALUop   = ex_q.alu_op;
    assign ex.ex_BrUn    = ex_q.br_un;
    assign ex.ex_br_type = ex_q.br_type;
    assign ex.ex_mem_re  = ex_q.mem_re;
    assign ex.ex_mem_we  = ex_q.mem_we;
    assign ex.ex_funct3  = ex_q.funct3;
    assign ex.ex_wb_en   = ex_q.wb_en;
    assign ex.ex_wb_sel  = ex_q.wb_sel;
    assign ex.ex_rd      = ex_q.rd;
    assign ex.ex_illegal = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each task drives one scenario and checks hand-computed values.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, flush, wb_en;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    int          nvec = 0;
    int          errs = 0;

    id_stage_if ex_if ();

    id_stage #(.NREG(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .ex       (ex_if)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_if.ex_ready = 1'b1;
        tick(); tick();
        nvec++; if (ex_if.ex_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %h exp 0", ex_if.ex_valid); end
        nvec++; if (ex_if.ex_imm !== 32'h0) begin errs++; $display("FAIL rst_imm got %h exp 0", ex_if.ex_imm); end
        nvec++; if (ex_if.ex_ALUop !== 4'd0) begin errs++; $display("FAIL rst_aluop got %h exp 0", ex_if.ex_ALUop); end
        nvec++; if (ex_if.ex_illegal !== 1'b0) begin errs++; $display("FAIL rst_illegal got %h exp 0", ex_if.ex_illegal); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
        #1;
        nvec++; if (if_ready !== 1'b1) begin errs++; $display("FAIL addi_ifready got %h exp 1", if_ready); end
        tick();
        if_valid = 1'b0;
        nvec++; if (ex_if.ex_valid !== 1'b1) begin errs++; $display("FAIL addi_valid got %h exp 1", ex_if.ex_valid); end
        nvec++; if (ex_if.ex_ASel !== 2'd0) begin errs++; $display("FAIL addi_asel got %h exp 0", ex_if.ex_ASel); end
        nvec++; if (ex_if.ex_BSel !== 2'd1) begin errs++; $display("FAIL addi_bsel got %h exp 1", ex_if.ex_BSel); end
        nvec++; if (ex_if.ex_imm !== 32'd5) begin errs++; $display("FAIL addi_imm got %h exp 5", ex_if.ex_imm); end
        nvec++; if (ex_if.ex_ALUop !== 4'd0) begin errs++; $display("FAIL addi_aluop got %h exp 0", ex_if.ex_ALUop); end
        nvec++; if (ex_if.ex_rd !== 5'd1) begin errs++; $display("FAIL addi_rd got %h exp 1", ex_if.ex_rd); end
        nvec++; if (ex_if.ex_wb_en !== 1'b1) begin errs++; $display("FAIL addi_wben got %h exp 1", ex_if.ex_wb_en); end
        nvec++; if (ex_if.ex_pc !== 32'h100) begin errs++; $display("FAIL addi_pc got %h exp 100", ex_if.ex_pc); end
    endtask

    task automatic test_write_through();
        // ADD x3,x2,x2 while writeback writes x2
        if_valid = 1'b1; if_instr = 32'h002101B3; if_pc = 32'h104;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234;
        tick();
        nvec++; if (ex_if.ex_DataA !== 32'h1234) begin errs++; $display("FAIL wt_dataa got %h exp 1234", ex_if.ex_DataA); end
        nvec++; if (ex_if.ex_DataB !== 32'h1234) begin errs++; $display("FAIL wt_datab got %h exp 1234", ex_if.ex_DataB); end
        nvec++; if (ex_if.ex_rd !== 5'd3) begin errs++; $display("FAIL wt_rd got %h exp 3", ex_if.ex_rd); end
        // ADD x4,x2,x0 reads stored x2; a concurrent write to x0 must not leak
        if_instr = 32'h00010233; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        wb_en = 1'b0; if_valid = 1'b0;
        nvec++; if (ex_if.ex_DataA !== 32'h1234) begin errs++; $display("FAIL rf_x2 got %h exp 1234", ex_if.ex_DataA); end
        nvec++; if (ex_if.ex_DataB !== 32'h0) begin errs++; $display("FAIL rf_x0 got %h exp 0", ex_if.ex_DataB); end
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = 32'h0000A283; // LW x5,0(x1)
        tick();
        nvec++; if (ex_if.ex_mem_re !== 1'b1) begin errs++; $display("FAIL lw_memre got %h exp 1", ex_if.ex_mem_re); end
        nvec++; if (ex_if.ex_wb_sel !== 2'd1) begin errs++; $display("FAIL lw_wbsel got %h exp 1", ex_if.ex_wb_sel); end
        if_instr = 32'h00528333; // ADD x6,x5,x5
        #1;
        nvec++; if (if_ready !== 1'b0) begin errs++; $display("FAIL lu_ifready got %h exp 0", if_ready); end
        tick();
        nvec++; if (ex_if.ex_valid !== 1'b0) begin errs++; $display("FAIL lu_bubble got %h exp 0", ex_if.ex_valid); end
        nvec++; if (if_ready !== 1'b1) begin errs++; $display("FAIL lu_release got %h exp 1", if_ready); end
        tick();
        nvec++; if (ex_if.ex_valid !== 1'b1) begin errs++; $display("FAIL lu_issue got %h exp 1", ex_if.ex_valid); end
        nvec++; if (ex_if.ex_rd !== 5'd6) begin errs++; $display("FAIL lu_rd got %h exp 6", ex_if.ex_rd); end
        if_instr = 32'h0000A283;
        tick();
        if_instr = 32'h000282B7; // LUI x5,0x28 (rs1 field aliases x5)
        #1;
        nvec++; if (if_ready !== 1'b1) begin errs++; $display("FAIL lui_nobubble got %h exp 1", if_ready); end
        tick();
        nvec++; if (ex_if.ex_imm !== 32'h00028000) begin errs++; $display("FAIL lui_imm got %h exp 28000", ex_if.ex_imm); end
        nvec++; if (ex_if.ex_ASel !== 2'd2) begin errs++; $display("FAIL lui_asel got %h exp 2", ex_if.ex_ASel); end
        if_valid = 1'b0;
    endtask

    task automatic test_branch();
        if_valid = 1'b1; if_instr = 32'hFE20ECE3; // BLTU x1,x2,-8
        tick();
        if_valid = 1'b0;
        nvec++; if (ex_if.ex_ASel !== 2'd1) begin errs++; $display("FAIL br_asel got %h exp 1", ex_if.ex_ASel); end
        nvec++; if (ex_if.ex_BSel !== 2'd1) begin errs++; $display("FAIL br_bsel got %h exp 1", ex_if.ex_BSel); end
        nvec++; if (ex_if.ex_imm !== 32'hFFFFFFF8) begin errs++; $display("FAIL br_imm got %h exp fffffff8", ex_if.ex_imm); end
        nvec++; if (ex_if.ex_BrUn !== 1'b1) begin errs++; $display("FAIL br_brun got %h exp 1", ex_if.ex_BrUn); end
        nvec++; if (ex_if.ex_br_type !== 3'd3) begin errs++; $display("FAIL br_type got %h exp 3", ex_if.ex_br_type); end
        nvec++; if (ex_if.ex_wb_en !== 1'b0) begin errs++; $display("FAIL br_wben got %h exp 0", ex_if.ex_wb_en); end
    endtask

    task automatic test_stall_flush();
        if_valid = 1'b1; if_instr = 32'hFFF00393; // ADDI x7,x0,-1
        tick();
        ex_if.ex_ready = 1'b0; if_instr = 32'h002101B3;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if (if_ready !== 1'b0) begin errs++; $display("FAIL stall_ifready[%0d] got %h exp 0", i, if_ready); end
            tick();
            nvec++; if (ex_if.ex_valid !== 1'b1 || ex_if.ex_imm !== 32'hFFFFFFFF || ex_if.ex_rd !== 5'd7) begin
                errs++; $display("FAIL stall_hold[%0d] got v=%h imm=%h rd=%h exp v=1 imm=ffffffff rd=7", i, ex_if.ex_valid, ex_if.ex_imm, ex_if.ex_rd);
            end
        end
        if_valid = 1'b0; flush = 1'b1;
        tick();
        nvec++; if (ex_if.ex_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %h exp 0", ex_if.ex_valid); end
        // flush together with an accepted instruction: handshake completes, result is dropped
        if_valid = 1'b1; ex_if.ex_ready = 1'b1;
        #1;
        nvec++; if (if_ready !== 1'b1) begin errs++; $display("FAIL flush_accept got %h exp 1", if_ready); end
        tick();
        flush = 1'b0; if_valid = 1'b0;
        nvec++; if (ex_if.ex_valid !== 1'b0) begin errs++; $display("FAIL flush_drop got %h exp 0", ex_if.ex_valid); end
    endtask

    task automatic test_illegal_reset();
        if_valid = 1'b1; if_instr = 32'h0000007F; if_pc = 32'h200;
        tick();
        if_valid = 1'b0;
        nvec++; if (ex_if.ex_illegal !== 1'b1) begin errs++; $display("FAIL ill_flag got %h exp 1", ex_if.ex_illegal); end
        nvec++; if (ex_if.ex_wb_en !== 1'b0) begin errs++; $display("FAIL ill_wben got %h exp 0", ex_if.ex_wb_en); end
        nvec++; if (ex_if.ex_mem_re !== 1'b0 || ex_if.ex_mem_we !== 1'b0) begin
            errs++; $display("FAIL ill_mem got re=%h we=%h exp 0 0", ex_if.ex_mem_re, ex_if.ex_mem_we);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvec++; if (ex_if.ex_valid !== 1'b0 || ex_if.ex_illegal !== 1'b0) begin
            errs++; $display("FAIL rst2_ctrl got v=%h ill=%h exp 0 0", ex_if.ex_valid, ex_if.ex_illegal);
        end
        nvec++; if (ex_if.ex_pc !== 32'h0 || ex_if.ex_imm !== 32'h0 || ex_if.ex_ASel !== 2'd0) begin
            errs++; $display("FAIL rst2_payload got pc=%h imm=%h asel=%h exp 0", ex_if.ex_pc, ex_if.ex_imm, ex_if.ex_ASel);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_write_through();
        test_load_use();
        test_branch();
        test_stall_flush();
        test_illegal_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
